// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer family.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, wrapping at NUM_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  grant_idx,
  output logic [NUM_CH-1:0] grant
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W:0]   idx_s;
  logic             found_s;

  // Priority search ptr, ptr+1, ..., wrapping; one extra bit keeps ptr+k from overflowing.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = {1'b0, ptr_q} + (SEL_W+1)'(k);
      idx_s = (idx_s >= (SEL_W+1)'(NUM_CH)) ? idx_s - (SEL_W+1)'(NUM_CH) : idx_s;
      if (!found_s && req[idx_s[SEL_W-1:0]]) begin
        grant[idx_s[SEL_W-1:0]] = 1'b1;
        found_s                 = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the granted channel, wrapping to 0.
  always_comb begin
    if (advance) begin
      if (grant_idx == SEL_W'(NUM_CH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SEL_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// Registered valid/ready N:1 multiplexer with fixed-select and round-robin modes.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
);

  logic [NUM_CH-1:0] fixed_grant_s;
  logic [NUM_CH-1:0] rr_grant_s;
  logic [NUM_CH-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [DATA_W-1:0] grant_data_s;
  logic              any_grant_s;
  logic              can_load_s;
  logic              advance_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (advance_s),
    .grant_idx (grant_idx_s),
    .grant     (rr_grant_s)
  );

  // Grant select; an out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    fixed_grant_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        fixed_grant_s[i] = in_valid[i];
      end else begin
        fixed_grant_s[i] = 1'b0;
      end
    end
    grant_s = (mode == MODE_RR) ? rr_grant_s : fixed_grant_s;
  end

  // Grant is one-hot, so OR-reduction yields the winning index and data.
  always_comb begin
    grant_idx_s  = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_idx_s  = grant_idx_s  | (grant_s[i] ? SEL_W'(i) : '0);
      grant_data_s = grant_data_s | ({DATA_W{grant_s[i]}} & in_data[i*DATA_W +: DATA_W]);
    end
  end

  assign any_grant_s = |grant_s;
  assign can_load_s  = !out_valid_q || out_ready;
  assign in_ready    = (rst_n && can_load_s) ? grant_s : '0;
  assign advance_s   = rst_n && can_load_s && any_grant_s && (mode == MODE_RR);

  // Output stage next state: load, drain, or hold under backpressure.
  always_comb begin
    if (can_load_s) begin
      out_valid_d = any_grant_s;
      if (any_grant_s) begin
        out_data_d = grant_data_s;
        out_ch_d   = grant_idx_s;
      end else begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
      end
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Table-driven bench for mux_nx1_stream (4 channels) plus a 3-channel instance for range/wrap cases.
module tb_mux_nx1_stream;

  localparam logic [31:0] D_IDX = 32'h03020100;
  localparam logic [31:0] D_A5  = 32'h44A52211;
  localparam logic [31:0] D_3C  = 32'hD3D23CD0;

  logic        clk = 1'b0;
  logic        rst_n, mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  logic        b_rst_n, b_mode, b_out_ready, b_out_valid;
  logic [1:0]  b_sel, b_out_ch;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [23:0] b_in_data;
  logic [7:0]  b_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_nx1_stream #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  mux_nx1_stream #(.NUM_CH(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .mode(b_mode), .sel(b_sel), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_ch(b_out_ch)
  );

  typedef struct packed {
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic        chk_d;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                     input logic [31:0] d, input logic o, input logic [3:0] er,
                     input logic eov, input logic ecd, input logic [7:0] eod, input logic [1:0] eoc);
    vec_t t;
    t = '{r, m, s, v, d, o, er, eov, ecd, eod, eoc};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Reset, RR fairness, alternating valids, backpressure, mode switch, fixed select, drain, reset mid-hold.
    add(1'b0,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h0,1'b0,1'b1,8'h00,2'd0);
    add(1'b0,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h0,1'b0,1'b1,8'h00,2'd0);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h1,1'b1,1'b1,8'h00,2'd0);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h2,1'b1,1'b1,8'h01,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h4,1'b1,1'b1,8'h02,2'd2);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h8,1'b1,1'b1,8'h03,2'd3);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h1,1'b1,1'b1,8'h00,2'd0);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h2,1'b1,1'b1,8'h01,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h4,1'b1,1'b1,8'h02,2'd2);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h8,1'b1,1'b1,8'h03,2'd3);
    add(1'b1,1'b1,2'd0,4'hA,D_IDX,1'b1,4'h2,1'b1,1'b1,8'h01,2'd1);
    add(1'b1,1'b1,2'd0,4'hA,D_IDX,1'b1,4'h8,1'b1,1'b1,8'h03,2'd3);
    add(1'b1,1'b1,2'd0,4'hA,D_IDX,1'b1,4'h2,1'b1,1'b1,8'h01,2'd1);
    add(1'b1,1'b1,2'd0,4'hA,D_IDX,1'b1,4'h8,1'b1,1'b1,8'h03,2'd3);
    add(1'b1,1'b1,2'd0,4'h2,D_3C, 1'b1,4'h2,1'b1,1'b1,8'h3C,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_3C, 1'b0,4'h0,1'b1,1'b1,8'h3C,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_3C, 1'b0,4'h0,1'b1,1'b1,8'h3C,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_3C, 1'b0,4'h0,1'b1,1'b1,8'h3C,2'd1);
    add(1'b1,1'b1,2'd0,4'hF,D_3C, 1'b1,4'h4,1'b1,1'b1,8'hD2,2'd2);
    add(1'b1,1'b0,2'd0,4'hF,D_IDX,1'b1,4'h1,1'b1,1'b1,8'h00,2'd0);
    add(1'b1,1'b0,2'd0,4'hF,D_IDX,1'b1,4'h1,1'b1,1'b1,8'h00,2'd0);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h8,1'b1,1'b1,8'h03,2'd3);
    add(1'b1,1'b0,2'd2,4'hF,D_A5, 1'b1,4'h4,1'b1,1'b1,8'hA5,2'd2);
    add(1'b1,1'b0,2'd2,4'hF,D_A5, 1'b1,4'h4,1'b1,1'b1,8'hA5,2'd2);
    add(1'b1,1'b0,2'd2,4'hB,D_A5, 1'b1,4'h0,1'b0,1'b0,8'h00,2'd0);
    add(1'b1,1'b0,2'd2,4'hF,D_A5, 1'b1,4'h4,1'b1,1'b1,8'hA5,2'd2);
    add(1'b1,1'b0,2'd2,4'hF,D_A5, 1'b0,4'h0,1'b1,1'b1,8'hA5,2'd2);
    add(1'b0,1'b0,2'd2,4'hF,D_A5, 1'b0,4'h0,1'b0,1'b1,8'h00,2'd0);
    add(1'b1,1'b1,2'd0,4'hF,D_IDX,1'b1,4'h1,1'b1,1'b1,8'h00,2'd0);

    b_rst_n = 1'b0; b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b111;
    b_in_data = 24'h626160; b_out_ready = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].valid; in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #2;
      chk($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk_d) begin
        chk($sformatf("out_data[%0d]", i), 32'(out_data), 32'(vecs[i].exp_od));
        chk($sformatf("out_ch[%0d]", i), 32'(out_ch), 32'(vecs[i].exp_oc));
      end
    end

    // Three-channel instance: out-of-range select, then RR wrap 0,1,2,0.
    @(posedge clk); #1;
    chk("b_reset_valid", 32'(b_out_valid), 32'd0);
    b_rst_n = 1'b1; b_mode = 1'b0; b_sel = 2'd3;
    #2;
    chk("b_oor_ready", 32'(b_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("b_oor_valid", 32'(b_out_valid), 32'd0);
    b_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ch;
      ch = 2'(k % 3);
      #2;
      chk($sformatf("b_rr_ready[%0d]", k), 32'(b_in_ready), 32'(3'b001 << ch));
      @(posedge clk); #1;
      chk($sformatf("b_rr_ch[%0d]", k), 32'(b_out_ch), 32'(ch));
      chk($sformatf("b_rr_data[%0d]", k), 32'(b_out_data), 32'(8'h60 + 8'(ch)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
